uart_receiver: RTL and testbench

//   Receive end of the team's 8N1 UART link; pairs with the UART transmitter on the far side of o_tx/i_rx.

---
 rtl/uart_receiver.sv | 182 ++++++++++++++++++
 tb/tb_uart_receiver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receive path: synchronise i_rx, find the start edge, sample each bit mid-period and emit the byte.
// Optional UART_RX_MAJORITY_VOTE_EN: each sample point becomes a 2-of-3 vote over three consecutive cycles.
module uart_receiver #(
  parameter int unsigned BAUD_RATE         = 10000,
  parameter int unsigned CLOCK_FREQUENCY   = 250000,
  parameter int unsigned CYCLES_PER_SAMPLE = CLOCK_FREQUENCY / BAUD_RATE,
  parameter int unsigned HALF_SAMPLE       = CYCLES_PER_SAMPLE / 2
) (
  input  logic       clk,
  input  logic       i_reset_n,
  input  logic       i_rx,
  output logic [0:7] o_data,
  output logic       o_valid,
  output logic       o_frame_error,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [15:0] LAST_COUNT = 16'(CYCLES_PER_SAMPLE - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
  // Start decision waits one extra cycle; later decisions inherit that shift.
  localparam logic [15:0] START_COUNT = 16'(HALF_SAMPLE + 1);
`else
  localparam logic [15:0] START_COUNT = 16'(HALF_SAMPLE);
`endif

  state_t      state;
  state_t      next_state;
  logic        rx_meta;
  logic        rx_s;
  logic        rx_d;
  logic [15:0] cycle_count;
  logic [3:0]  bit_index;
  logic [0:7]  shift_reg;
  logic        start_edge;
  logic        at_start_point;
  logic        at_bit_end;
  logic        sample_bit;
  logic        valid_next;
  logic        frame_error_next;
  logic        busy_next;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] rx_hist;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_hist <= '1;
    end else begin
      rx_hist <= {rx_hist[0], rx_s};
    end
  end

  always_comb begin
    sample_bit = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & rx_s) | (rx_hist[0] & rx_s);
  end
`else
  always_comb begin
    sample_bit = rx_s;
  end
`endif

  always_comb begin
    start_edge     = (rx_s == 1'b0) && (rx_d == 1'b1);
    at_start_point = (cycle_count == START_COUNT);
    at_bit_end     = (cycle_count == LAST_COUNT);
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        // Edge-triggered, so a line held low after a break cannot re-arm.
        if (start_edge) next_state = START;
      end
      START: begin
        if (at_start_point) next_state = sample_bit ? IDLE : DATA;
      end
      DATA: begin
        if (at_bit_end && (bit_index == 4'd7)) next_state = STOP;
      end
      STOP: begin
        if (at_bit_end) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cycle_count <= '0;
      bit_index   <= '0;
      shift_reg   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cycle_count <= '0;
          bit_index   <= '0;
        end
        START: begin
          if (at_start_point) begin
            cycle_count <= '0;
            bit_index   <= '0;
          end else begin
            cycle_count <= cycle_count + 16'd1;
          end
        end
        DATA: begin
          if (at_bit_end) begin
            shift_reg[bit_index[2:0]] <= sample_bit;
            cycle_count               <= '0;
            bit_index                 <= (bit_index == 4'd7) ? 4'd0 : bit_index + 4'd1;
          end else begin
            cycle_count <= cycle_count + 16'd1;
          end
        end
        STOP: begin
          if (at_bit_end) begin
            cycle_count <= '0;
          end else begin
            cycle_count <= cycle_count + 16'd1;
          end
        end
        default: begin
          cycle_count <= '0;
          bit_index   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    valid_next       = 1'b0;
    frame_error_next = 1'b0;
    busy_next        = (next_state != IDLE);
    if ((state == STOP) && at_bit_end) begin
      valid_next       = sample_bit;
      frame_error_next = !sample_bit;
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_data        <= '0;
      o_valid       <= 1'b0;
      o_frame_error <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      o_valid       <= valid_next;
      o_frame_error <= frame_error_next;
      o_busy        <= busy_next;
      if (valid_next) o_data <= shift_reg;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: framed bytes, back-to-back traffic, glitch, break, mid-frame reset.
module tb_uart_receiver;

  localparam int unsigned CPS = 25;

  logic       clk;
  logic       i_reset_n;
  logic       i_rx;
  logic [0:7] o_data;
  logic       o_valid;
  logic       o_frame_error;
  logic       o_busy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  logic [0:7]  valid_q[$];
  int unsigned n_valid = 0;
  int unsigned n_ferr = 0;
  int unsigned n_both = 0;
  int unsigned valid_cyc = 0;

  uart_receiver #(
    .BAUD_RATE(10000),
    .CLOCK_FREQUENCY(250000)
  ) dut (
    .clk(clk),
    .i_reset_n(i_reset_n),
    .i_rx(i_rx),
    .o_data(o_data),
    .o_valid(o_valid),
    .o_frame_error(o_frame_error),
    .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid) begin
      valid_q.push_back(o_data);
      n_valid   = n_valid + 1;
      valid_cyc = cyc;
    end
    if (o_frame_error) n_ferr = n_ferr + 1;
    if (o_valid && o_frame_error) n_both = n_both + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    valid_q.delete();
    n_valid = 0;
    n_ferr  = 0;
  endtask

  task automatic idle(input int unsigned n);
    i_rx = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [0:9] frame(input logic [0:7] d, input logic stop);
    return {1'b0, d, stop};
  endfunction

  function automatic logic [0:7] q_at(input int unsigned i);
    if (i < valid_q.size()) return valid_q[i];
    return 'x;
  endfunction

  // Line bit k is held for CPS cycles; glitch flips one cycle in the middle of each data bit.
  task automatic send_line(input logic [0:9] line, input int unsigned ncyc, input bit glitch);
    int unsigned k;
    int unsigned c;
    for (int unsigned t = 0; t < ncyc; t++) begin
      k = t / CPS;
      c = t % CPS;
      i_rx = line[k] ^ (glitch && (k >= 1) && (k <= 8) && (c == 13));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int unsigned t0;
    int unsigned lat;
    logic [0:7] exp_glitch;

    i_reset_n = 1'b0;
    i_rx      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", 32'(o_data), 32'h00);
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_ferr", 32'(o_frame_error), 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd0);
    i_reset_n = 1'b1;
    idle(10);

    // Single byte and latency from the falling start edge
    clear_mon();
    t0 = cyc;
    send_line(frame(8'hA5, 1'b1), 10 * CPS, 1'b0);
    idle(10);
    lat = valid_cyc - t0;
    chk("a5_count", n_valid, 1);
    chk("a5_data", 32'(q_at(0)), 32'hA5);
    chk("a5_ferr", n_ferr, 0);
    chk("a5_busy_after", 32'(o_busy), 32'd0);
    chk("a5_latency", 32'((lat >= 240) && (lat <= 242)), 32'd1);

    // Back-to-back frames, including one non-symmetric bit pattern
    clear_mon();
    send_line(frame(8'h00, 1'b1), 10 * CPS, 1'b0);
    send_line(frame(8'hFF, 1'b1), 10 * CPS, 1'b0);
    send_line(frame(8'h3C, 1'b1), 10 * CPS, 1'b0);
    send_line(frame(8'h12, 1'b1), 10 * CPS, 1'b0);
    idle(10);
    chk("b2b_count", n_valid, 4);
    chk("b2b_data0", 32'(q_at(0)), 32'h00);
    chk("b2b_data1", 32'(q_at(1)), 32'hFF);
    chk("b2b_data2", 32'(q_at(2)), 32'h3C);
    chk("b2b_data3", 32'(q_at(3)), 32'h12);
    chk("b2b_hold", 32'(o_data), 32'h12);
    chk("b2b_first_bit", 32'(o_data[0]), 32'd0);

    // Short low glitch on an idle line is rejected at the start-bit midpoint
    clear_mon();
    send_line(10'b0000000000, 5, 1'b0);
    idle(5);
    chk("glitch_busy_mid", 32'(o_busy), 32'd1);
    idle(15);
    chk("glitch_busy_end", 32'(o_busy), 32'd0);
    chk("glitch_valid", n_valid, 0);
    chk("glitch_ferr", n_ferr, 0);

    // Break: one framing error, no retrigger while the line stays low
    clear_mon();
    i_rx = 1'b0;
    repeat (300) begin
      @(posedge clk);
      #1;
    end
    chk("break_ferr", n_ferr, 1);
    chk("break_busy_low", 32'(o_busy), 32'd0);
    repeat (75) begin
      @(posedge clk);
      #1;
    end
    idle(20);
    chk("break_ferr_once", n_ferr, 1);
    chk("break_valid", n_valid, 0);
    chk("break_data_kept", 32'(o_data), 32'h12);

    // Reset in the middle of data bit 4, then a clean frame
    clear_mon();
    send_line(frame(8'hE7, 1'b1), 5 * CPS + 12, 1'b0);
    i_reset_n = 1'b0;
    #1;
    chk("midrst_data", 32'(o_data), 32'h00);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_valid", 32'(o_valid), 32'd0);
    i_rx = 1'b1;
    @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    idle(10);
    chk("midrst_no_pulse", n_valid + n_ferr, 0);
    clear_mon();
    send_line(frame(8'h5A, 1'b1), 10 * CPS, 1'b0);
    idle(10);
    chk("5a_count", n_valid, 1);
    chk("5a_data", 32'(q_at(0)), 32'h5A);
    chk("5a_ferr", n_ferr, 0);

    // One-cycle inverted glitch at every data mid-bit
`ifdef UART_RX_MAJORITY_VOTE_EN
    exp_glitch = 8'hC3;
`else
    exp_glitch = ~8'hC3;
`endif
    clear_mon();
    send_line(frame(8'hC3, 1'b1), 10 * CPS, 1'b1);
    idle(10);
    chk("vote_count", n_valid, 1);
    chk("vote_data", 32'(q_at(0)), 32'(exp_glitch));

    chk("never_both", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
